// File: rtl/weight_ram_loader.sv
// Assembles a little-endian byte stream into DATA_WIDTH words and writes them
// to consecutive RAM addresses, one load of num_words words per start request.
module weight_ram_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic                  abort,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  output logic                  s_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [BCW-1:0]      LAST_BYTE = BCW'(BYTES - 1);
  localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } state_e;

  state_e                  state_q;
  logic                    load_q;
  logic [BCW-1:0]          byte_cnt_q;
  logic [ADDR_WIDTH:0]     word_idx_q;
  logic [ADDR_WIDTH:0]     words_q;
  logic [DATA_WIDTH-1:0]   word_q;
  logic [DATA_WIDTH-1:0]   word_d;
  logic                    wr_en_q;
  logic [ADDR_WIDTH-1:0]   wr_addr_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;
  logic                    done_q;

  logic accept;
  logic last_byte;
  logic last_word;

  // load_q mirrors state==LOAD, so ready never depends on s_valid.
  assign accept    = s_valid & load_q;
  assign last_byte = (byte_cnt_q == LAST_BYTE);
  assign last_word = (word_idx_q == words_q - 1'b1);

  // Partial word with the incoming byte dropped into its lane.
  always_comb begin
    // NOTE: default first so every path assigns word_d and no latch is inferred.
    word_d = word_q;
    word_d[int'(byte_cnt_q) * 8 +: 8] = s_data;
  end

  // NOTE: non-blocking assignments for all state so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      load_q     <= 1'b0;
      byte_cnt_q <= '0;
      word_idx_q <= '0;
      words_q    <= '0;
      word_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            byte_cnt_q <= '0;
            word_idx_q <= '0;
            word_q     <= '0;
            if (num_words == '0) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end else begin
              words_q <= (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
              state_q <= LOAD;
              load_q  <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (abort) begin
            // Abort outranks a byte accepted this cycle, suppressing its write.
            state_q    <= IDLE;
            load_q     <= 1'b0;
            byte_cnt_q <= '0;
            word_q     <= '0;
          end else if (accept) begin
            if (last_byte) begin
              byte_cnt_q <= '0;
              word_q     <= '0;
              wr_en_q    <= 1'b1;
              wr_addr_q  <= word_idx_q[ADDR_WIDTH-1:0];
              wr_data_q  <= word_d;
              word_idx_q <= word_idx_q + 1'b1;
              if (last_word) begin
                state_q <= FINISH;
                load_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              word_q     <= word_d;
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
        end
        FINISH: state_q <= IDLE;
        default: begin
          state_q <= IDLE;
          load_q  <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready = load_q;
  assign busy    = load_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign done    = done_q;

endmodule

// File: tb/tb_weight_ram_loader.sv
// Randomized bench for weight_ram_loader (ADDR_WIDTH=4, DATA_WIDTH=32), checked
// against a byte-list model of the expected RAM writes.
module tb_weight_ram_loader;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int BYTES = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW:0]   num_words;
  logic          abort;
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;

  weight_ram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
    .abort(abort), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Observed write log, filled away from the active edge.
  int            cyc = 0;
  logic [AW-1:0] wq_addr[$];
  logic [DW-1:0] wq_data[$];
  int            wr_cyc[$];
  int            done_cnt = 0;
  int            done_cyc = -1;
  int            ready_seen = 0;

  logic [7:0]    stim[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
      wr_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (s_ready) ready_seen = ready_seen + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    wq_addr.delete();
    wq_data.delete();
    wr_cyc.delete();
    done_cnt   = 0;
    done_cyc   = -1;
    ready_seen = 0;
  endtask

  task automatic fill_random(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(8'($urandom_range(255)));
  endtask

  // Word w of the stream: byte 4w in bits [7:0], byte 4w+1 in [15:8], ...
  function automatic logic [DW-1:0] model_word(input int w);
    logic [DW-1:0] r;
    r = '0;
    for (int b = 0; b < BYTES; b++) r = r | (DW'(stim[w * BYTES + b]) << (8 * b));
    return r;
  endfunction

  // Starts a load and offers stim bytes until the stream is exhausted or ready
  // has stayed low for a few cycles after being high. Optionally pulses start
  // again at cycle glitch_at to probe that it is ignored while busy.
  task automatic drive_load(input int nw, input int gap_pct, input int glitch_at,
                            output int accepted);
    int cycles;
    int tail;
    bit v;
    bit rdy;
    bit seen_ready;
    accepted = 0; cycles = 0; tail = 0; seen_ready = 0;
    @(negedge clk);
    start = 1'b1;
    num_words = nw[AW:0];
    @(negedge clk);
    start = 1'b0;
    while (cycles < 600 && accepted < stim.size() && tail < 4) begin
      v = ($urandom_range(99) >= gap_pct);
      s_valid = v;
      s_data  = stim[accepted];
      if (cycles == glitch_at) begin
        start = 1'b1;
        num_words = 5'd1;
      end else begin
        start = 1'b0;
      end
      rdy = s_ready;
      if (rdy) seen_ready = 1'b1;
      else if (seen_ready) tail++;
      @(posedge clk);
      if (v && rdy) accepted++;
      @(negedge clk);
      cycles++;
    end
    s_valid = 1'b0;
    start   = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    #3;
    total_cnt++; if ({s_ready, wr_en, busy, done} !== 4'b0) $display("FAIL reset_ctrl: got %b want 0000", {s_ready, wr_en, busy, done}); else pass_cnt++;
    total_cnt++; if ({wr_addr, wr_data} !== '0) $display("FAIL reset_data: got %0h want 0", {wr_addr, wr_data}); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int acc;
    clear_mon();
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(8'(i));
    drive_load(3, 0, -1, acc);
    total_cnt++; if (acc !== 12) $display("FAIL basic_bytes_consumed: got %0d want 12", acc); else pass_cnt++;
    total_cnt++; if (wq_addr.size() !== 3) $display("FAIL basic_write_count: got %0d want 3", wq_addr.size()); else pass_cnt++;
    for (int i = 0; i < wq_addr.size() && i < 3; i++) begin
      total_cnt++; if (wq_addr[i] !== AW'(i)) $display("FAIL basic_addr[%0d]: got %0d want %0d", i, wq_addr[i], i); else pass_cnt++;
      total_cnt++; if (wq_data[i] !== model_word(i)) $display("FAIL basic_data[%0d]: got %h want %h", i, wq_data[i], model_word(i)); else pass_cnt++;
    end
    for (int i = 1; i < wr_cyc.size(); i++) begin
      total_cnt++; if (wr_cyc[i] - wr_cyc[i-1] !== BYTES) $display("FAIL basic_throughput[%0d]: got %0d want %0d", i, wr_cyc[i] - wr_cyc[i-1], BYTES); else pass_cnt++;
    end
    total_cnt++; if (done_cnt !== 1) $display("FAIL basic_done_count: got %0d want 1", done_cnt); else pass_cnt++;
    if (wr_cyc.size() > 0) begin
      total_cnt++; if (done_cyc !== wr_cyc[wr_cyc.size()-1]) $display("FAIL basic_done_with_last_write: got cyc %0d want %0d", done_cyc, wr_cyc[wr_cyc.size()-1]); else pass_cnt++;
    end
    total_cnt++; if ({s_ready, busy} !== 2'b00) $display("FAIL basic_idle_after: got %b want 00", {s_ready, busy}); else pass_cnt++;
  endtask

  task automatic test_zero_words();
    int c0;
    clear_mon();
    @(negedge clk);
    start = 1'b1;
    num_words = '0;
    s_valid = 1'b1;
    s_data = 8'hA5;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
    total_cnt++; if (done_cnt !== 1) $display("FAIL zero_done_count: got %0d want 1", done_cnt); else pass_cnt++;
    total_cnt++; if (done_cyc !== c0 + 1) $display("FAIL zero_done_latency: got cyc %0d want %0d", done_cyc, c0 + 1); else pass_cnt++;
    total_cnt++; if (ready_seen !== 0) $display("FAIL zero_ready_seen: got %0d want 0", ready_seen); else pass_cnt++;
    total_cnt++; if (wq_addr.size() !== 0) $display("FAIL zero_write_count: got %0d want 0", wq_addr.size()); else pass_cnt++;
  endtask

  task automatic test_random_gaps();
    int acc;
    clear_mon();
    fill_random(16 * BYTES + 8);
    drive_load(16, 50, 5, acc);
    total_cnt++; if (acc !== 16 * BYTES) $display("FAIL gaps_bytes_consumed: got %0d want %0d", acc, 16 * BYTES); else pass_cnt++;
    total_cnt++; if (wq_addr.size() !== 16) $display("FAIL gaps_write_count: got %0d want 16", wq_addr.size()); else pass_cnt++;
    for (int i = 0; i < wq_addr.size() && i < 16; i++) begin
      total_cnt++; if (wq_addr[i] !== AW'(i)) $display("FAIL gaps_addr[%0d]: got %0d want %0d", i, wq_addr[i], i); else pass_cnt++;
      total_cnt++; if (wq_data[i] !== model_word(i)) $display("FAIL gaps_data[%0d]: got %h want %h", i, wq_data[i], model_word(i)); else pass_cnt++;
    end
    total_cnt++; if (done_cnt !== 1) $display("FAIL gaps_done_count: got %0d want 1", done_cnt); else pass_cnt++;
  endtask

  task automatic test_clamp();
    int acc;
    clear_mon();
    fill_random(20 * BYTES);
    drive_load(20, 20, -1, acc);
    total_cnt++; if (acc !== 16 * BYTES) $display("FAIL clamp_bytes_consumed: got %0d want %0d", acc, 16 * BYTES); else pass_cnt++;
    total_cnt++; if (wq_addr.size() !== 16) $display("FAIL clamp_write_count: got %0d want 16", wq_addr.size()); else pass_cnt++;
    for (int i = 0; i < wq_addr.size() && i < 16; i++) begin
      total_cnt++; if (wq_addr[i] !== AW'(i)) $display("FAIL clamp_addr[%0d]: got %0d want %0d", i, wq_addr[i], i); else pass_cnt++;
      total_cnt++; if (wq_data[i] !== model_word(i)) $display("FAIL clamp_data[%0d]: got %h want %h", i, wq_data[i], model_word(i)); else pass_cnt++;
    end
    total_cnt++; if (done_cnt !== 1) $display("FAIL clamp_done_count: got %0d want 1", done_cnt); else pass_cnt++;
  endtask

  // Abort a 4-word load after n_before accepted bytes; the abort cycle may
  // also present a byte, which must be dropped.
  task automatic test_abort(input int n_before, input bit valid_in_abort);
    int            acc;
    logic [DW-1:0] w0;
    clear_mon();
    fill_random(16);
    w0 = model_word(0);
    @(negedge clk);
    start = 1'b1;
    num_words = 5'd4;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n_before; i++) begin
      s_valid = 1'b1;
      s_data  = stim[i];
      @(negedge clk);
    end
    abort   = 1'b1;
    s_valid = valid_in_abort;
    s_data  = stim[n_before];
    @(negedge clk);
    abort   = 1'b0;
    s_valid = 1'b0;
    total_cnt++; if ({busy, s_ready} !== 2'b00) $display("FAIL abort%0d_idle_next: got %b want 00", n_before, {busy, s_ready}); else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++; if (wq_addr.size() !== 1) $display("FAIL abort%0d_write_count: got %0d want 1", n_before, wq_addr.size()); else pass_cnt++;
    if (wq_addr.size() > 0) begin
      total_cnt++; if (wq_addr[0] !== '0) $display("FAIL abort%0d_addr: got %0d want 0", n_before, wq_addr[0]); else pass_cnt++;
      total_cnt++; if (wq_data[0] !== w0) $display("FAIL abort%0d_data: got %h want %h", n_before, wq_data[0], w0); else pass_cnt++;
    end
    total_cnt++; if (done_cnt !== 0) $display("FAIL abort%0d_no_done: got %0d want 0", n_before, done_cnt); else pass_cnt++;

    clear_mon();
    fill_random(2 * BYTES);
    drive_load(1, 0, -1, acc);
    total_cnt++; if (wq_addr.size() !== 1) $display("FAIL abort%0d_reload_count: got %0d want 1", n_before, wq_addr.size()); else pass_cnt++;
    if (wq_addr.size() > 0) begin
      total_cnt++; if (wq_addr[0] !== '0) $display("FAIL abort%0d_reload_addr: got %0d want 0", n_before, wq_addr[0]); else pass_cnt++;
      total_cnt++; if (wq_data[0] !== model_word(0)) $display("FAIL abort%0d_reload_data: got %h want %h", n_before, wq_data[0], model_word(0)); else pass_cnt++;
    end
    total_cnt++; if (done_cnt !== 1) $display("FAIL abort%0d_reload_done: got %0d want 1", n_before, done_cnt); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    clear_mon();
    fill_random(12);
    @(negedge clk);
    start = 1'b1;
    num_words = 5'd3;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = stim[i];
      @(negedge clk);
    end
    s_valid = 1'b0;
    total_cnt++; if (busy !== 1'b1) $display("FAIL areset_busy_before: got %b want 1", busy); else pass_cnt++;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if ({s_ready, wr_en, busy, done} !== 4'b0) $display("FAIL areset_ctrl: got %b want 0000", {s_ready, wr_en, busy, done}); else pass_cnt++;
    total_cnt++; if (wr_addr !== '0) $display("FAIL areset_addr: got %0d want 0", wr_addr); else pass_cnt++;
    total_cnt++; if (wr_data !== '0) $display("FAIL areset_data: got %h want 0", wr_data); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++; if ({busy, s_ready} !== 2'b00) $display("FAIL areset_no_resume: got %b want 00", {busy, s_ready}); else pass_cnt++;
    test_basic();
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    num_words = '0;
    abort     = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    test_reset();
    test_basic();
    test_zero_words();
    test_random_gaps();
    test_clamp();
    test_abort(6, 1'b0);
    test_abort(7, 1'b1);
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
